// File: rtl/ball_motion.sv
// Per-frame tilt integration for the Labyrinth ball icon. Each frame first integrates velocity,
// then moves X and then Y, and each axis move is checked with two wall-lookup probes before it commits.
`timescale 1ns/1ps
module ball_motion #(
    parameter int ICON_WIDTH  = 15,
    parameter int ICON_HEIGHT = 15,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int START_X     = 16,
    parameter int START_Y     = 16,
    parameter int VEL_MAX     = 7,
    parameter int ACC_SHIFT   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_tick,
    input  logic signed [7:0] accel_x,
    input  logic signed [7:0] accel_y,
    input  logic              accel_valid,
    input  logic              restart,
    output logic              wall_req,
    output logic [9:0]        wall_addr_x,
    output logic [8:0]        wall_addr_y,
    input  logic              wall_hit,
    output logic [9:0]        bot_LocX,
    output logic [8:0]        bot_LocY,
    output logic              moving,
    output logic              busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_VEL, S_PX0, S_PX1, S_WX0, S_WX1, S_PY0, S_PY1, S_WY0, S_WY1
    } state_t;

    localparam logic signed [10:0] VEL_POS = 11'(VEL_MAX * 16);
    localparam logic signed [10:0] VEL_NEG = -VEL_POS;
    localparam logic signed [10:0] X_MAX   = 11'(SCREEN_W - ICON_WIDTH);
    localparam logic signed [10:0] Y_MAX   = 11'(SCREEN_H - ICON_HEIGHT);
    localparam logic [9:0]         X_SPAN  = 10'(ICON_WIDTH - 1);
    localparam logic [8:0]         Y_SPAN  = 9'(ICON_HEIGHT - 1);
    localparam logic [9:0]         X_START = 10'(START_X);
    localparam logic [8:0]         Y_START = 9'(START_Y);

    function automatic logic signed [9:0] satVel(input logic signed [10:0] v);
        if (v > VEL_POS) return VEL_POS[9:0];
        if (v < VEL_NEG) return VEL_NEG[9:0];
        return v[9:0];
    endfunction

    function automatic logic [9:0] clampX(input logic signed [10:0] v);
        if (v < 11'sd0) return '0;
        if (v > X_MAX) return X_MAX[9:0];
        return v[9:0];
    endfunction

    function automatic logic [8:0] clampY(input logic signed [10:0] v);
        if (v < 11'sd0) return '0;
        if (v > Y_MAX) return Y_MAX[8:0];
        return v[8:0];
    endfunction

    state_t state_q, state_d;

    logic [9:0]        locX_q, locX_d;
    logic [8:0]        locY_q, locY_d;
    logic signed [9:0] velX_q, velX_d, velY_q, velY_d;
    logic signed [7:0] accX_q, accX_d, accY_q, accY_d;
    logic [9:0]        nx_q, nx_d, edgeX_q, edgeX_d;
    logic [8:0]        ny_q, ny_d, edgeY_q, edgeY_d;
    logic              stepXnz_q, stepXnz_d, stepYnz_q, stepYnz_d;
    logic              hitA_q, hitA_d;
    logic              wallReq_q, wallReq_d;
    logic [9:0]        addrX_q, addrX_d;
    logic [8:0]        addrY_q, addrY_d;
    logic              moving_q, moving_d;

    logic signed [10:0] accStepX, accStepY, velSumX, velSumY;
    logic signed [9:0]  velNewX, velNewY;
    logic signed [10:0] stepX, stepY, nxRaw, nyRaw;
    logic [9:0]         nxNew, edgeXNew;
    logic [8:0]         nyNew, edgeYNew;
    logic               clampedX, clampedY;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (frame_tick) state_d = S_VEL;
                S_VEL:   state_d = S_PX0;
                S_PX0:   state_d = S_PX1;
                S_PX1:   state_d = S_WX0;
                S_WX0:   state_d = S_WX1;
                S_WX1:   state_d = S_PY0;
                S_PY0:   state_d = S_PY1;
                S_PY1:   state_d = S_WY0;
                S_WY0:   state_d = S_WY1;
                S_WY1:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Velocity integration and the clamped target/leading edge, all evaluated while in VEL.
    always_comb begin
        accStepX = $signed({{3{accX_q[7]}}, accX_q}) >>> ACC_SHIFT;
        accStepY = $signed({{3{accY_q[7]}}, accY_q}) >>> ACC_SHIFT;
        velSumX  = $signed({velX_q[9], velX_q}) + accStepX;
        velSumY  = $signed({velY_q[9], velY_q}) + accStepY;
        velNewX  = satVel(velSumX);
        velNewY  = satVel(velSumY);
        stepX    = $signed({velNewX[9], velNewX}) >>> 4;
        stepY    = $signed({velNewY[9], velNewY}) >>> 4;
        nxRaw    = $signed({1'b0, locX_q}) + stepX;
        nyRaw    = $signed({2'b00, locY_q}) + stepY;
        nxNew    = clampX(nxRaw);
        nyNew    = clampY(nyRaw);
        clampedX = (nxRaw < 11'sd0) || (nxRaw > X_MAX);
        clampedY = (nyRaw < 11'sd0) || (nyRaw > Y_MAX);
        edgeXNew = (stepX > 11'sd0) ? nxNew + X_SPAN : nxNew;
        edgeYNew = (stepY > 11'sd0) ? nyNew + Y_SPAN : nyNew;
    end

    always_comb begin
        locX_d    = locX_q;
        locY_d    = locY_q;
        velX_d    = velX_q;
        velY_d    = velY_q;
        accX_d    = accX_q;
        accY_d    = accY_q;
        nx_d      = nx_q;
        ny_d      = ny_q;
        edgeX_d   = edgeX_q;
        edgeY_d   = edgeY_q;
        stepXnz_d = stepXnz_q;
        stepYnz_d = stepYnz_q;
        hitA_d    = hitA_q;
        wallReq_d = 1'b0;
        addrX_d   = addrX_q;
        addrY_d   = addrY_q;

        if (accel_valid) begin
            accX_d = accel_x;
            accY_d = accel_y;
        end

        if (restart) begin
            locX_d = X_START;
            locY_d = Y_START;
            velX_d = '0;
            velY_d = '0;
        end else begin
            // Probe strobes are registered, so each is raised one state ahead of the P* state it belongs to.
            case (state_q)
                S_VEL: begin
                    velX_d    = clampedX ? '0 : velNewX;
                    velY_d    = clampedY ? '0 : velNewY;
                    nx_d      = nxNew;
                    ny_d      = nyNew;
                    edgeX_d   = edgeXNew;
                    edgeY_d   = edgeYNew;
                    stepXnz_d = (stepX != 11'sd0);
                    stepYnz_d = (stepY != 11'sd0);
                    if (stepX != 11'sd0) begin
                        wallReq_d = 1'b1;
                        addrX_d   = edgeXNew;
                        addrY_d   = locY_q;
                    end
                end
                S_PX0: begin
                    if (stepXnz_q) begin
                        wallReq_d = 1'b1;
                        addrX_d   = edgeX_q;
                        addrY_d   = locY_q + Y_SPAN;
                    end
                end
                S_WX0, S_WY0: hitA_d = wall_hit;
                S_WX1: begin
                    if (stepXnz_q) begin
                        if (hitA_q || wall_hit) velX_d = '0;
                        else                    locX_d = nx_q;
                    end
                    if (stepYnz_q) begin
                        wallReq_d = 1'b1;
                        addrX_d   = locX_d;
                        addrY_d   = edgeY_q;
                    end
                end
                S_PY0: begin
                    if (stepYnz_q) begin
                        wallReq_d = 1'b1;
                        addrX_d   = locX_q + X_SPAN;
                        addrY_d   = edgeY_q;
                    end
                end
                S_WY1: begin
                    if (stepYnz_q) begin
                        if (hitA_q || wall_hit) velY_d = '0;
                        else                    locY_d = ny_q;
                    end
                end
                default: ;
            endcase
        end

        moving_d = (velX_d != '0) || (velY_d != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            locX_q    <= X_START;
            locY_q    <= Y_START;
            velX_q    <= '0;
            velY_q    <= '0;
            accX_q    <= '0;
            accY_q    <= '0;
            nx_q      <= '0;
            ny_q      <= '0;
            edgeX_q   <= '0;
            edgeY_q   <= '0;
            stepXnz_q <= 1'b0;
            stepYnz_q <= 1'b0;
            hitA_q    <= 1'b0;
            wallReq_q <= 1'b0;
            addrX_q   <= '0;
            addrY_q   <= '0;
            moving_q  <= 1'b0;
        end else begin
            locX_q    <= locX_d;
            locY_q    <= locY_d;
            velX_q    <= velX_d;
            velY_q    <= velY_d;
            accX_q    <= accX_d;
            accY_q    <= accY_d;
            nx_q      <= nx_d;
            ny_q      <= ny_d;
            edgeX_q   <= edgeX_d;
            edgeY_q   <= edgeY_d;
            stepXnz_q <= stepXnz_d;
            stepYnz_q <= stepYnz_d;
            hitA_q    <= hitA_d;
            wallReq_q <= wallReq_d;
            addrX_q   <= addrX_d;
            addrY_q   <= addrY_d;
            moving_q  <= moving_d;
        end
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        wall_req    = wallReq_q;
        wall_addr_x = addrX_q;
        wall_addr_y = addrY_q;
        bot_LocX    = locX_q;
        bot_LocY    = locY_q;
        moving      = moving_q;
    end

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: directed scenarios plus random tilt, checked against a per-frame
// arithmetic model of the ball and an address-based wall map that answers lookups.
`timescale 1ns/1ps
module tb_ball_motion;

    logic              clk = 1'b0;
    logic              reset_n, frame_tick, accel_valid, restart;
    logic              wall_hit = 1'b0;
    logic signed [7:0] accel_x, accel_y;
    logic              wall_req, moving, busy;
    logic [9:0]        wall_addr_x, bot_LocX;
    logic [8:0]        wall_addr_y, bot_LocY;

    int checks = 0;
    int errors = 0;

    ball_motion dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
        .accel_x(accel_x), .accel_y(accel_y), .accel_valid(accel_valid),
        .restart(restart), .wall_req(wall_req), .wall_addr_x(wall_addr_x),
        .wall_addr_y(wall_addr_y), .wall_hit(wall_hit), .bot_LocX(bot_LocX),
        .bot_LocY(bot_LocY), .moving(moving), .busy(busy)
    );

    always #5 clk = ~clk;

    // Wall map: optional vertical band, horizontal band, or everything.
    bit wallOnX = 0, wallOnY = 0, wallAll = 0;
    int wallXLo = 0, wallYLo = 0;

    function automatic bit isWall(input int x, input int y);
        return wallAll || (wallOnX && x >= wallXLo && x <= wallXLo + 9)
                       || (wallOnY && y >= wallYLo && y <= wallYLo + 9);
    endfunction

    // Lookup responder: answer appears exactly two cycles after the request cycle.
    logic hitPipe = 1'b0;
    always @(posedge clk) begin
        hitPipe  <= wall_req && isWall(int'(wall_addr_x), int'(wall_addr_y));
        wall_hit <= hitPipe;
    end

    int reqX[$], reqY[$];
    int busyCycles = 0;
    always @(negedge clk) begin
        if (wall_req === 1'b1) begin
            reqX.push_back(int'(wall_addr_x));
            reqY.push_back(int'(wall_addr_y));
        end
        if (busy === 1'b1) busyCycles++;
    end

    // Reference model state, whole pixels and 1/16 px/frame velocity.
    int mX, mY, mVx, mVy, mAx, mAy;
    int expReqX[$], expReqY[$];

    function automatic int floorDiv16(input int v);
        return (v >= 0) ? v / 16 : -((-v + 15) / 16);
    endfunction

    function automatic int satV(input int v);
        return (v > 112) ? 112 : ((v < -112) ? -112 : v);
    endfunction

    task automatic modelReset();
        mX = 16; mY = 16; mVx = 0; mVy = 0;
    endtask

    task automatic modelFrame();
        int vx, vy, dx, dy, nx, ny, ex, ey;
        expReqX.delete(); expReqY.delete();
        vx = satV(mVx + floorDiv16(mAx));
        vy = satV(mVy + floorDiv16(mAy));
        dx = floorDiv16(vx);
        dy = floorDiv16(vy);
        nx = mX + dx;
        if (nx < 0) begin nx = 0; vx = 0; end
        else if (nx > 640 - 15) begin nx = 640 - 15; vx = 0; end
        ny = mY + dy;
        if (ny < 0) begin ny = 0; vy = 0; end
        else if (ny > 480 - 15) begin ny = 480 - 15; vy = 0; end
        if (dx != 0) begin
            ex = (dx > 0) ? nx + 14 : nx;
            expReqX.push_back(ex); expReqY.push_back(mY);
            expReqX.push_back(ex); expReqY.push_back(mY + 14);
            if (isWall(ex, mY) || isWall(ex, mY + 14)) vx = 0;
            else mX = nx;
        end
        if (dy != 0) begin
            ey = (dy > 0) ? ny + 14 : ny;
            expReqX.push_back(mX);      expReqY.push_back(ey);
            expReqX.push_back(mX + 14); expReqY.push_back(ey);
            if (isWall(mX, ey) || isWall(mX + 14, ey)) vy = 0;
            else mY = ny;
        end
        mVx = vx;
        mVy = vy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int ax, input int ay);
        @(negedge clk);
        accel_x = 8'(ax);
        accel_y = 8'(ay);
        accel_valid = 1'b1;
        @(negedge clk);
        accel_valid = 1'b0;
        mAx = ax;
        mAy = ay;
    endtask

    task automatic doRestart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        modelReset();
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".X"}, bot_LocX, 16);
        checkOutput({tag, ".Y"}, bot_LocY, 16);
        checkOutput({tag, ".busy"}, busy, 0);
        checkOutput({tag, ".req"}, wall_req, 0);
        checkOutput({tag, ".moving"}, moving, 0);
    endtask

    task automatic runFrame(input bit extraTick);
        int n;
        modelFrame();
        reqX.delete(); reqY.delete();
        busyCycles = 0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        n = 0;
        while (busy && n < 30) begin
            frame_tick = extraTick && (n == 3);
            @(negedge clk);
            n++;
        end
        frame_tick = 1'b0;
        checkOutput("frameDone", busy, 0);
        checkOutput("busyLen", busyCycles, 9);
        checkOutput("locX", bot_LocX, mX);
        checkOutput("locY", bot_LocY, mY);
        checkOutput("moving", moving, (mVx != 0 || mVy != 0) ? 1 : 0);
        checkOutput("reqCount", reqX.size(), expReqX.size());
        for (int i = 0; i < reqX.size() && i < expReqX.size(); i++) begin
            checkOutput("reqAddrX", reqX[i], expReqX[i]);
            checkOutput("reqAddrY", reqY[i], expReqY[i]);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b1; frame_tick = 1'b0; accel_valid = 1'b0; restart = 1'b0;
        accel_x = '0; accel_y = '0;
        mAx = 0; mAy = 0;
        modelReset();

        // Asynchronous reset mid-clock.
        #3 reset_n = 1'b0;
        #1 checkReset("rst0");
        checkOutput("rst0.addrX", wall_addr_x, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Gentle acceleration: three frames without a whole-pixel step, then one pixel.
        applyStimulus(64, 0);
        repeat (4) runFrame(1'b0);
        checkOutput("acc.X", bot_LocX, 17);
        checkOutput("acc.req0", (reqX.size() > 0) ? reqX[0] * 1000 + reqY[0] : -1, 31016);
        checkOutput("acc.req1", (reqX.size() > 1) ? reqX[1] * 1000 + reqY[1] : -1, 31030);

        // Negative tilt from rest rounds toward -inf: one pixel left.
        doRestart();
        applyStimulus(-1, 0);
        runFrame(1'b0);
        checkOutput("neg.X", bot_LocX, 15);

        // Saturate right into the screen edge while pushing up into the top edge.
        doRestart();
        applyStimulus(127, -128);
        for (int f = 0; f < 100; f++) runFrame(f % 7 == 2);
        checkOutput("clamp.X", bot_LocX, 625);
        checkOutput("clamp.Y", bot_LocY, 0);

        // Vertical wall ahead: X probes hit, Y keeps moving.
        doRestart();
        wallOnX = 1; wallXLo = 60;
        applyStimulus(127, 16);
        for (int f = 0; f < 24; f++) runFrame(f % 3 == 0);
        checkOutput("wall.Xstop", (int'(bot_LocX) <= 45) ? 1 : 0, 1);
        wallOnX = 0;

        // Restart while the second X probe is out and its hit is still in flight.
        doRestart();
        applyStimulus(127, 0);
        repeat (3) runFrame(1'b0);
        wallAll = 1;
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        @(negedge clk);
        checkOutput("rst.px0Req", wall_req, 1);
        @(negedge clk);
        checkOutput("rst.px1Req", wall_req, 1);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        checkReset("rstMid");
        repeat (6) @(negedge clk);
        checkOutput("rstMid.X", bot_LocX, 16);
        checkOutput("rstMid.busy", busy, 0);
        wallAll = 0;
        modelReset();

        // Random tilt over a changing wall map.
        for (int f = 0; f < 120; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                wallOnX = 1'($urandom_range(0, 1));
                wallOnY = 1'($urandom_range(0, 1));
                wallXLo = int'($urandom_range(40, 600));
                wallYLo = int'($urandom_range(40, 440));
            end
            if ($urandom_range(0, 24) == 0) doRestart();
            if ($urandom_range(0, 2) != 0)
                applyStimulus(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
            runFrame(1'($urandom_range(0, 1)));
        end

        // Force the ball off start, then reset asynchronously between edges.
        wallOnX = 0; wallOnY = 0;
        doRestart();
        applyStimulus(127, 127);
        repeat (6) runFrame(1'b0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 checkReset("rst1");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
